// File: rtl/reg_write_arbiter_pkg.sv
// ============================================================================
// Module      : reg_write_arbiter_pkg
// Description : Shared types and constants for the register-file write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_write_arbiter_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [0:0] {
        LOAD_PRI = 1'b0,
        ALU_PRI  = 1'b1
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/reg_write_mux.sv
// ============================================================================
// Module      : reg_write_mux
// Description : Selects register write data between ALU result and load data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_write_mux
    import reg_write_arbiter_pkg::*;
(
    input  logic              data_read,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] data_result,
    output logic [DATA_W-1:0] reg_write_data
);

    assign reg_write_data = data_read ? data_result : alu_result;

endmodule

`default_nettype wire

// File: rtl/reg_write_arbiter.sv
// ============================================================================
// Module      : reg_write_arbiter
// Description : Arbitrates ALU / load writeback onto the single register-file
//               write port (load priority with ALU starvation guard).
//               Optional macro REG_WRITE_ARB_R0_FILTER_EN suppresses r0 writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int MAX_WAIT = 4
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_stall,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_result,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] data_result,
    output logic              mem_ready,
    output logic              w_en,
    output logic [ADDR_W-1:0] w_addr,
    output logic [DATA_W-1:0] w_data,
    output logic              w_src_load
);

    localparam int                 c_cnt_w      = $clog2(MAX_WAIT + 1);
    localparam logic [c_cnt_w-1:0] c_wait_limit = c_cnt_w'(MAX_WAIT);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [c_cnt_w-1:0] r_wait_cnt;
    logic [c_cnt_w-1:0] w_wait_cnt_nxt;

    logic               w_alu_gnt;
    logic               w_mem_gnt;
    logic               w_any_gnt;
    logic               w_wr_ok;
    logic [ADDR_W-1:0]  w_sel_rd;
    logic [DATA_W-1:0]  w_sel_data;

    logic               r_en;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_data;
    logic               r_src_load;

    always_comb begin
        w_alu_gnt      = 1'b0;
        w_mem_gnt      = 1'b0;
        w_wait_cnt_nxt = r_wait_cnt;
        w_state_nxt    = r_state;
        if (!wb_stall) begin
            case (r_state)
                LOAD_PRI: begin
                    w_mem_gnt = mem_valid;
                    w_alu_gnt = alu_valid & ~mem_valid;
                end
                ALU_PRI: begin
                    w_alu_gnt = alu_valid;
                    w_mem_gnt = mem_valid & ~alu_valid;
                end
                default: ;
            endcase

            // Saturates at the limit so an oversized count can never wrap back to zero.
            if (!alu_valid || w_alu_gnt) begin
                w_wait_cnt_nxt = '0;
            end else if (r_wait_cnt != c_wait_limit) begin
                w_wait_cnt_nxt = r_wait_cnt + 1'b1;
            end

            case (r_state)
                LOAD_PRI: if (w_wait_cnt_nxt == c_wait_limit) w_state_nxt = ALU_PRI;
                ALU_PRI:  if (w_alu_gnt || !alu_valid)        w_state_nxt = LOAD_PRI;
                default:  w_state_nxt = LOAD_PRI;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= LOAD_PRI;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    assign alu_ready = w_alu_gnt;
    assign mem_ready = w_mem_gnt;
    assign w_any_gnt = w_alu_gnt | w_mem_gnt;
    assign w_sel_rd  = w_mem_gnt ? mem_rd : alu_rd;

    reg_write_mux u_reg_write_mux (
        .data_read      (w_mem_gnt),
        .alu_result     (alu_result),
        .data_result    (data_result),
        .reg_write_data (w_sel_data)
    );

`ifdef REG_WRITE_ARB_R0_FILTER_EN
    // r0 requests still complete the handshake but never reach the register file.
    assign w_wr_ok = (w_sel_rd != '0);
`else
    assign w_wr_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_src_load <= 1'b0;
        end else if (w_any_gnt && w_wr_ok) begin
            r_en       <= 1'b1;
            r_addr     <= w_sel_rd;
            r_data     <= w_sel_data;
            r_src_load <= w_mem_gnt;
        end else begin
            r_en       <= 1'b0;
        end
    end

    assign w_en       = r_en;
    assign w_addr     = r_addr;
    assign w_data     = r_data;
    assign w_src_load = r_src_load;

endmodule

`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
// ============================================================================
// Module      : tb_reg_write_arbiter
// Description : Self-checking bench for reg_write_arbiter against a
//               loss-count reference model and a shadow register file.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_reg_write_arbiter;

    localparam int ADDR_W   = 4;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_stall;
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [15:0]       alu_result;
    logic              alu_ready;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_rd;
    logic [15:0]       data_result;
    logic              mem_ready;
    logic              w_en;
    logic [ADDR_W-1:0] w_addr;
    logic [15:0]       w_data;
    logic              w_src_load;

    always #5 clk = ~clk;

    reg_write_arbiter #(
        .ADDR_W   (ADDR_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_stall    (wb_stall),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_result  (alu_result),
        .alu_ready   (alu_ready),
        .mem_valid   (mem_valid),
        .mem_rd      (mem_rd),
        .data_result (data_result),
        .mem_ready   (mem_ready),
        .w_en        (w_en),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .w_src_load  (w_src_load)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: ALU gets priority once it has lost MAX_WAIT unstalled cycles in a row.
    int                m_losses;
    bit                m_en;
    bit                m_src;
    logic [ADDR_W-1:0] m_addr;
    logic [15:0]       m_data;
    bit                g_alu;
    bit                g_mem;
    bit                s_alu_rdy;
    bit                s_mem_rdy;
    logic [15:0]       exp_rf [16];
    logic [15:0]       act_rf [16];
    int                win_idx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_losses = 0;
        m_en     = 1'b0;
        m_src    = 1'b0;
        m_addr   = '0;
        m_data   = '0;
    endtask

    task automatic predict();
        g_alu = 1'b0;
        g_mem = 1'b0;
        if (!wb_stall) begin
            if (m_losses >= MAX_WAIT) begin
                g_alu = alu_valid;
                g_mem = mem_valid && !alu_valid;
            end else begin
                g_mem = mem_valid;
                g_alu = alu_valid && !mem_valid;
            end
        end
    endtask

    task automatic model_edge();
        logic [ADDR_W-1:0] rd;
        logic [15:0]       d;
        bit                wr;
        m_en = 1'b0;
        if (!wb_stall) begin
            if (g_alu || g_mem) begin
                rd = g_mem ? mem_rd : alu_rd;
                d  = g_mem ? data_result : alu_result;
                wr = 1'b1;
`ifdef REG_WRITE_ARB_R0_FILTER_EN
                if (rd == '0) wr = 1'b0;
`endif
                if (wr) begin
                    m_en       = 1'b1;
                    m_addr     = rd;
                    m_data     = d;
                    m_src      = g_mem;
                    exp_rf[rd] = d;
                end
            end
            if (alu_valid && !g_alu) begin
                if (m_losses < MAX_WAIT) m_losses++;
            end else begin
                m_losses = 0;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        predict();
        s_alu_rdy = alu_ready;
        s_mem_rdy = mem_ready;
        check("alu_ready", alu_ready, g_alu);
        check("mem_ready", mem_ready, g_mem);
        check("w_en", w_en, m_en);
        check("w_addr", w_addr, m_addr);
        check("w_data", w_data, m_data);
        if (m_en) check("w_src_load", w_src_load, m_src);
        if (w_en === 1'b1) act_rf[w_addr] = w_data;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        wb_stall  = 1'b0;
        repeat (n) cycle();
    endtask

    initial begin
        rst         = 1'b1;
        wb_stall    = 1'b0;
        alu_valid   = 1'b0;
        alu_rd      = '0;
        alu_result  = '0;
        mem_valid   = 1'b0;
        mem_rd      = '0;
        data_result = '0;
        model_reset();
        for (int i = 0; i < 16; i++) begin
            exp_rf[i] = '0;
            act_rf[i] = '0;
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_w_en", w_en, 0);
        check("rst_w_addr", w_addr, 0);
        check("rst_w_data", w_data, 0);
        check("rst_w_src", w_src_load, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Both valid in LOAD_PRI: load first, ALU next.
        alu_valid = 1'b1; alu_rd = 4'd3; alu_result = 16'hA003;
        mem_valid = 1'b1; mem_rd = 4'd5; data_result = 16'hB005;
        cycle();
        check("t1_mem_first", s_mem_rdy, 1);
        check("t1_w_addr", w_addr, 5);
        check("t1_w_data", w_data, 16'hB005);
        check("t1_w_src", w_src_load, 1);
        mem_valid = 1'b0;
        cycle();
        check("t1_alu_next", s_alu_rdy, 1);
        idle(2);

        // ALU starved by a continuous load stream.
        alu_valid = 1'b1; alu_rd = 4'd2; alu_result = 16'hA002;
        mem_valid = 1'b1;
        win_idx = -1;
        for (int i = 0; i < 7 && win_idx < 0; i++) begin
            mem_rd = ADDR_W'(8 + (i % 4)); data_result = 16'hB100 + 16'(i);
            cycle();
            if (s_alu_rdy) win_idx = i;
        end
        check("t2_alu_win_cycle", win_idx, MAX_WAIT);
        check("t2_w_addr", w_addr, 2);
        alu_rd = 4'd4; alu_result = 16'hA004;
        cycle();
        check("t2_back_load_pri", s_mem_rdy, 1);
        idle(2);

        // Stall freezes grants and the loss count.
        alu_valid = 1'b1; alu_rd = 4'd6; alu_result = 16'hA006;
        mem_valid = 1'b1; mem_rd = 4'd7; data_result = 16'hB007;
        repeat (2) begin
            cycle();
            data_result = data_result + 16'd1;
        end
        wb_stall = 1'b1;
        repeat (3) cycle();
        wb_stall = 1'b0;
        cycle();
        check("t3_release_mem", s_mem_rdy, 1);
        repeat (2) cycle();
        check("t3_alu_after_freeze", s_alu_rdy, 1);
        idle(2);

        // Reset in the middle of a grant.
        alu_valid = 1'b1; alu_rd = 4'd7; alu_result = 16'h1234;
        @(negedge clk);
        check("t4_alu_ready", alu_ready, 1);
        #1 rst = 1'b1; alu_valid = 1'b0;
        #1;
        check("t4_w_en", w_en, 0);
        check("t4_w_addr", w_addr, 0);
        check("t4_w_data", w_data, 0);
        model_reset();
        @(posedge clk);
        #1;
        check("t4_no_write", w_en, 0);
        rst = 1'b0;
        idle(1);
        alu_valid = 1'b1; alu_rd = 4'd1; alu_result = 16'hA001;
        mem_valid = 1'b1; mem_rd = 4'd1; data_result = 16'hB001;
        cycle();
        check("t4_load_pri", s_mem_rdy, 1);
        mem_valid = 1'b0;
        cycle();
        idle(2);

        // Back-to-back ALU stream to r0..r3.
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1; alu_rd = ADDR_W'(i); alu_result = 16'h5000 + 16'(i);
            cycle();
            check("t5_grant", s_alu_rdy, 1);
`ifndef REG_WRITE_ARB_R0_FILTER_EN
            check("t5_w_en", w_en, 1);
            check("t5_w_addr", w_addr, i);
`endif
        end
        idle(2);

        // Same destination from both sources: loser's value lands last.
        alu_valid = 1'b1; alu_rd = 4'd9; alu_result = 16'hA009;
        mem_valid = 1'b1; mem_rd = 4'd9; data_result = 16'hC009;
        cycle();
        mem_valid = 1'b0;
        cycle();
        idle(2);
        check("t6_same_rd_last", act_rf[9], 16'hA009);

        // Randomized traffic with holding sources.
        alu_valid = 1'b0; mem_valid = 1'b0; g_alu = 1'b0; g_mem = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!alu_valid || g_alu) begin
                alu_valid  = ($urandom_range(0, 3) != 0);
                alu_rd     = ADDR_W'($urandom);
                alu_result = 16'($urandom);
            end
            if (!mem_valid || g_mem) begin
                mem_valid   = ($urandom_range(0, 1) != 0);
                mem_rd      = ADDR_W'($urandom);
                data_result = 16'($urandom);
            end
            wb_stall = ($urandom_range(0, 9) == 0);
            cycle();
        end
        idle(3);

        for (int i = 0; i < 16; i++) begin
            check($sformatf("rf%0d", i), act_rf[i], exp_rf[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
